// File: rtl/uart_transmitter.sv
// rtl/uart_transmitter.sv - 8N1 UART transmitter with optional even parity symbol
// Optional feature macro: UART_TX_PARITY_EN (adds one even-parity symbol after the data bits)
module uart_transmitter #(
  parameter int CLOCK_FREQ = 125_000_000,
  parameter int BAUD_RATE  = 115_200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic       ready_out,
  output logic       serial_out
);

  localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
  localparam int CW               = $clog2(SYMBOL_EDGE_TIME);
  localparam logic [CW-1:0] SYM_LAST = CW'(SYMBOL_EDGE_TIME - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_STOP   = 3'd3;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd4;
`endif

  // A symbol must span at least two clocks so the counter has a real width.
  if (SYMBOL_EDGE_TIME < 2) begin : g_bad_ratio
    $error("uart_transmitter: CLOCK_FREQ / BAUD_RATE must be at least 2");
  end

  logic [2:0]    r_state;
  logic [CW-1:0] r_sym_cnt;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shift;
  logic          r_serial;

  logic          w_sym_end;
  logic [2:0]    w_next_idx;

  assign w_sym_end  = (r_sym_cnt == SYM_LAST);
  assign w_next_idx = r_bit_idx + 3'd1;

  // Ready is gated by rst so a handshake can never be seen during reset.
  assign ready_out  = (r_state == S_IDLE) && !rst;
  assign serial_out = r_serial;

`ifdef UART_TX_PARITY_EN
  logic w_parity;
  assign w_parity = ^r_shift;
`endif

  // Symbol timer: held at 0 while idle, free-runs 0..SYMBOL_EDGE_TIME-1 inside a frame.
  always_ff @(posedge clk) begin
    if (rst || (r_state == S_IDLE) || w_sym_end) begin
      r_sym_cnt <= '0;
    end else begin
      r_sym_cnt <= r_sym_cnt + CW'(1);
    end
  end

  // Frame sequencer: the line level for the next symbol is registered on the same
  // edge that changes state, so serial_out switches exactly at symbol boundaries.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_bit_idx <= 3'd0;
      r_shift   <= 8'h00;
      r_serial  <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_serial <= 1'b1;
          if (valid_in) begin
            r_shift  <= data_in;
            r_state  <= S_START;
            r_serial <= 1'b0;
          end
        end
        S_START: begin
          if (w_sym_end) begin
            r_state   <= S_DATA;
            r_bit_idx <= 3'd0;
            r_serial  <= r_shift[0];
          end
        end
        S_DATA: begin
          if (w_sym_end) begin
            if (r_bit_idx == 3'd7) begin
              r_bit_idx <= 3'd0;
`ifdef UART_TX_PARITY_EN
              r_state   <= S_PARITY;
              r_serial  <= w_parity;
`else
              r_state   <= S_STOP;
              r_serial  <= 1'b1;
`endif
            end else begin
              r_bit_idx <= w_next_idx;
              r_serial  <= r_shift[w_next_idx];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (w_sym_end) begin
            r_state  <= S_STOP;
            r_serial <= 1'b1;
          end
        end
`endif
        S_STOP: begin
          if (w_sym_end) begin
            r_state  <= S_IDLE;
            r_serial <= 1'b1;
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_serial <= 1'b1;
        end
      endcase
    end
  end

endmodule
